// File: rtl/mdu_seq_if.sv
// Handshake bundle between the EXE stage and the RV32M multi-cycle sequencer.
// The pipeline side is the master; the sequencer is the slave.
interface mdu_seq_if #(
    parameter int XLEN = 32
);
    logic            start_i_MDU;
    logic [2:0]      op_i_MDU;
    logic [XLEN-1:0] Rd_Data1_i_MDU;
    logic [XLEN-1:0] Rd_Data2_i_MDU;
    logic [4:0]      Wt_Addr_i_MDU;
    logic            regWrite_i_MDU;
    logic            flush_i_MDU;
    logic            stall_o_MDU;
    logic            busy_o_MDU;
    logic [XLEN-1:0] Wt_Data_o_MDU;
    logic [4:0]      Wt_Addr_o_MDU;
    logic            Wt_Enable_o_MDU;

    modport master (
        output start_i_MDU, op_i_MDU, Rd_Data1_i_MDU, Rd_Data2_i_MDU,
               Wt_Addr_i_MDU, regWrite_i_MDU, flush_i_MDU,
        input  stall_o_MDU, busy_o_MDU, Wt_Data_o_MDU, Wt_Addr_o_MDU, Wt_Enable_o_MDU
    );

    modport slave (
        input  start_i_MDU, op_i_MDU, Rd_Data1_i_MDU, Rd_Data2_i_MDU,
               Wt_Addr_i_MDU, regWrite_i_MDU, flush_i_MDU,
        output stall_o_MDU, busy_o_MDU, Wt_Data_o_MDU, Wt_Addr_o_MDU, Wt_Enable_o_MDU
    );
endinterface

// File: rtl/mdu_seq.sv
// RV32M sequencer: 32-iteration shift-add multiply / restoring divide on magnitudes,
// sign fixed on the way out, result presented as a one-cycle register write.
module mdu_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic      clk_i_MDU,
    input  logic      rst_i_MDU,
    mdu_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [2:0] OP_MUL  = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV  = 3'd4, OP_DIVU = 3'd5, OP_REM    = 3'd6, OP_REMU  = 3'd7;

    function automatic logic [XLEN-1:0] fn_cneg32(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] fn_cneg64(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? (~v + (2*XLEN)'(1)) : v;
    endfunction

    state_t              r_state;
    logic                r_busy;
    logic [CNT_W-1:0]    r_cnt;
    logic [XLEN-1:0]     r_wdata;
    logic [4:0]          r_waddr;
    logic                r_wen;

    logic [2:0]          r_op;
    logic [4:0]          r_rd;
    logic                r_we;
    logic                r_neg;
    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_rem;

    logic signed [XLEN-1:0] w_rs1, w_rs2;
    logic                w_neg1, w_neg2, w_res_neg;
    logic                w_accept, w_special, w_div_zero, w_ovf;
    logic [XLEN-1:0]     w_special_data;
    logic [XLEN:0]       w_msum;
    logic [2*XLEN-1:0]   w_acc_nxt, w_prod_fix;
    logic [XLEN:0]       w_shift;
    logic [XLEN-1:0]     w_diff, w_rem_nxt, w_quo_nxt, w_calc_data;
    logic                w_ge;

    assign w_rs1 = bus.Rd_Data1_i_MDU;
    assign w_rs2 = bus.Rd_Data2_i_MDU;

    assign w_neg1 = w_rs1[XLEN-1] & (bus.op_i_MDU inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    assign w_neg2 = w_rs2[XLEN-1] & (bus.op_i_MDU inside {OP_MULH, OP_DIV, OP_REM});
    // Remainders follow the dividend; products and quotients follow the sign product.
    assign w_res_neg = bus.op_i_MDU[2] & bus.op_i_MDU[1] ? w_neg1 : (w_neg1 ^ w_neg2);

    assign w_div_zero = (w_rs2 == '0);
    assign w_ovf      = (bus.op_i_MDU inside {OP_DIV, OP_REM}) &&
                        (w_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (w_rs2 == '1);
    assign w_special  = bus.op_i_MDU[2] & (w_div_zero | w_ovf);
    assign w_special_data = w_div_zero ? (bus.op_i_MDU[1] ? bus.Rd_Data1_i_MDU : '1)
                                       : (bus.op_i_MDU[1] ? '0 : bus.Rd_Data1_i_MDU);

    assign w_accept = (r_state == IDLE) & bus.start_i_MDU & ~bus.flush_i_MDU;

    // Multiply step: r_acc = {partial product, remaining multiplier bits}.
    assign w_msum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_acc_nxt = {w_msum, r_acc[XLEN-1:1]};

    // Divide step: r_acc low half shifts the dividend out and the quotient in.
    assign w_shift   = {r_rem, r_acc[XLEN-1]};
    assign w_ge      = (w_shift >= {1'b0, r_b});
    assign w_diff    = w_shift[XLEN-1:0] - r_b;
    assign w_rem_nxt = w_ge ? w_diff : w_shift[XLEN-1:0];
    assign w_quo_nxt = {r_acc[XLEN-2:0], w_ge};

    assign w_prod_fix = fn_cneg64(w_acc_nxt, r_neg);

    always_comb begin
        w_calc_data = '0;
        case (r_op)
            OP_MUL:                       w_calc_data = w_prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_calc_data = w_prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_calc_data = fn_cneg32(w_quo_nxt, r_neg);
            default:                      w_calc_data = fn_cneg32(w_rem_nxt, r_neg);
        endcase
    end

    always_ff @(posedge clk_i_MDU or posedge rst_i_MDU) begin
        if (rst_i_MDU) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_wdata <= '0;
            r_waddr <= '0;
            r_wen   <= 1'b0;
        end else if (bus.flush_i_MDU) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_wen   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start_i_MDU) begin
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        if (w_special) begin
                            r_state <= DONE;
                            r_wdata <= w_special_data;
                            r_waddr <= bus.Wt_Addr_i_MDU;
                            r_wen   <= bus.regWrite_i_MDU;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(XLEN-1)) begin
                        r_state <= DONE;
                        r_wdata <= w_calc_data;
                        r_waddr <= r_rd;
                        r_wen   <= r_we;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_wen   <= 1'b0;
                end
            endcase
        end
    end

    // Operand/accumulator datapath; contents are don't-care outside CALC.
    always_ff @(posedge clk_i_MDU) begin
        if (w_accept) begin
            r_op  <= bus.op_i_MDU;
            r_rd  <= bus.Wt_Addr_i_MDU;
            r_we  <= bus.regWrite_i_MDU;
            r_neg <= w_res_neg;
            r_a   <= fn_cneg32(w_rs1, w_neg1);
            r_b   <= fn_cneg32(w_rs2, w_neg2);
            r_acc <= {{XLEN{1'b0}}, bus.op_i_MDU[2] ? fn_cneg32(w_rs1, w_neg1) : fn_cneg32(w_rs2, w_neg2)};
            r_rem <= '0;
        end else if (r_state == CALC) begin
            if (r_op[2]) begin
                r_rem              <= w_rem_nxt;
                r_acc[XLEN-1:0]    <= w_quo_nxt;
            end else begin
                r_acc <= w_acc_nxt;
            end
        end
    end

    assign bus.stall_o_MDU     = w_accept | (r_state == CALC);
    assign bus.busy_o_MDU      = r_busy;
    assign bus.Wt_Data_o_MDU   = r_wdata;
    assign bus.Wt_Addr_o_MDU   = r_waddr;
    assign bus.Wt_Enable_o_MDU = r_wen;
endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: arithmetic reference model plus scoreboard on the write port,
// with literal expectations per vector and latency/flush/reset checks.
module tb_mdu_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tot = 0;
    int   n_bad = 0;
    logic [36:0] q[$];

    mdu_seq_if #(.XLEN(32)) bus ();

    mdu_seq #(.XLEN(32), .CNT_W(6)) dut (
        .clk_i_MDU (clk),
        .rst_i_MDU (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: RISC-V M semantics with 64-bit integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            3'd0: r = sa * sb;
            3'd1: r = (sa * sb) >>> 32;
            3'd2: r = (sa * ub) >>> 32;
            3'd3: r = (ua * ub) >> 32;
            3'd4: r = (b == 0) ? -1 : sa / sb;
            3'd5: r = (b == 0) ? -1 : ua / ub;
            3'd6: r = (b == 0) ? sa : sa % sb;
            default: r = (b == 0) ? ua : ua % ub;
        endcase
        return r[31:0];
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.Wt_Enable_o_MDU) begin
            if (q.size() == 0) begin
                check("unexpected_wen", {31'b0, bus.Wt_Enable_o_MDU}, 32'd0);
            end else begin
                logic [36:0] e;
                e = q.pop_front();
                check("sb_data", bus.Wt_Data_o_MDU, e[31:0]);
                check("sb_addr", {27'b0, bus.Wt_Addr_o_MDU}, {27'b0, e[36:32]});
            end
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic we, input logic [31:0] lit,
                          input int exp_stall);
        logic [31:0] m;
        int cnt;
        m = model(op, a, b);
        check("model_pin", m, lit);
        if (we) q.push_back({rd, m});
        @(negedge clk);
        bus.start_i_MDU    = 1'b1;
        bus.op_i_MDU       = op;
        bus.Rd_Data1_i_MDU = a;
        bus.Rd_Data2_i_MDU = b;
        bus.Wt_Addr_i_MDU  = rd;
        bus.regWrite_i_MDU = we;
        cnt = 0;
        #1;
        while (bus.stall_o_MDU && cnt < 100) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        check("stall_len", 32'(cnt), 32'(exp_stall));
        check("wen_done", {31'b0, bus.Wt_Enable_o_MDU}, {31'b0, we});
        check("data_done", bus.Wt_Data_o_MDU, lit);
        check("addr_done", {27'b0, bus.Wt_Addr_o_MDU}, {27'b0, rd});
        check("busy_done", {31'b0, bus.busy_o_MDU}, 32'd1);
        bus.start_i_MDU = 1'b0;
    endtask

    initial begin
        bus.start_i_MDU    = 1'b0;
        bus.op_i_MDU       = 3'd0;
        bus.Rd_Data1_i_MDU = '0;
        bus.Rd_Data2_i_MDU = '0;
        bus.Wt_Addr_i_MDU  = '0;
        bus.regWrite_i_MDU = 1'b0;
        bus.flush_i_MDU    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", {31'b0, bus.stall_o_MDU}, 32'd0);
        check("rst_busy", {31'b0, bus.busy_o_MDU}, 32'd0);
        check("rst_wen", {31'b0, bus.Wt_Enable_o_MDU}, 32'd0);
        check("rst_data", bus.Wt_Data_o_MDU, 32'd0);
        check("rst_addr", {27'b0, bus.Wt_Addr_o_MDU}, 32'd0);
        rst = 1'b0;

        run_op(3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  1'b1, 32'hFFFFFFEB, 33);
        run_op(3'd1, 32'h80000000, 32'h80000000, 5'd6,  1'b1, 32'h40000000, 33);
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  1'b1, 32'hFFFFFFFE, 33);
        run_op(3'd2, 32'hFFFFFFFF, 32'd2,        5'd8,  1'b1, 32'hFFFFFFFF, 33);
        run_op(3'd1, 32'hFFFFFFFE, 32'd3,        5'd9,  1'b1, 32'hFFFFFFFF, 33);
        run_op(3'd4, 32'hFFFFFFF9, 32'd2,        5'd10, 1'b1, 32'hFFFFFFFD, 33);
        run_op(3'd6, 32'hFFFFFFF9, 32'd2,        5'd11, 1'b1, 32'hFFFFFFFF, 33);
        run_op(3'd5, 32'd100,      32'd7,        5'd12, 1'b1, 32'd14,       33);
        run_op(3'd7, 32'd100,      32'd7,        5'd13, 1'b1, 32'd2,        33);
        run_op(3'd4, 32'hFFFFFFF8, 32'hFFFFFFFD, 5'd14, 1'b1, 32'd2,        33);
        run_op(3'd6, 32'hFFFFFFF8, 32'hFFFFFFFD, 5'd15, 1'b1, 32'hFFFFFFFE, 33);
        run_op(3'd5, 32'hFFFFFFFF, 32'd1,        5'd16, 1'b1, 32'hFFFFFFFF, 33);
        run_op(3'd5, 32'd5,        32'd0,        5'd17, 1'b1, 32'hFFFFFFFF, 1);
        run_op(3'd6, 32'd5,        32'd0,        5'd18, 1'b1, 32'd5,        1);
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd19, 1'b1, 32'h80000000, 1);
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd20, 1'b1, 32'd0,        1);
        run_op(3'd0, 32'h12345678, 32'd9,        5'd0,  1'b1, 32'hA3D70A38, 33);
        run_op(3'd5, 32'd50,       32'd5,        5'd21, 1'b0, 32'd10,       33);

        // Flush in the tenth CALC cycle of a divide.
        @(negedge clk);
        bus.start_i_MDU    = 1'b1;
        bus.op_i_MDU       = 3'd4;
        bus.Rd_Data1_i_MDU = 32'd1000;
        bus.Rd_Data2_i_MDU = 32'd7;
        bus.Wt_Addr_i_MDU  = 5'd3;
        bus.regWrite_i_MDU = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("flush_pre_busy", {31'b0, bus.busy_o_MDU}, 32'd1);
        bus.flush_i_MDU = 1'b1;
        bus.start_i_MDU = 1'b0;
        @(negedge clk);
        bus.flush_i_MDU = 1'b0;
        #1;
        check("flush_stall", {31'b0, bus.stall_o_MDU}, 32'd0);
        check("flush_busy", {31'b0, bus.busy_o_MDU}, 32'd0);
        check("flush_wen", {31'b0, bus.Wt_Enable_o_MDU}, 32'd0);
        repeat (3) @(negedge clk);
        run_op(3'd5, 32'd9, 32'd3, 5'd22, 1'b1, 32'd3, 33);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        bus.start_i_MDU    = 1'b1;
        bus.op_i_MDU       = 3'd0;
        bus.Rd_Data1_i_MDU = 32'd3;
        bus.Rd_Data2_i_MDU = 32'd5;
        bus.Wt_Addr_i_MDU  = 5'd9;
        repeat (6) @(negedge clk);
        #2;
        check("midcalc_busy", {31'b0, bus.busy_o_MDU}, 32'd1);
        rst = 1'b1;
        bus.start_i_MDU = 1'b0;
        #1;
        check("arst_stall", {31'b0, bus.stall_o_MDU}, 32'd0);
        check("arst_busy", {31'b0, bus.busy_o_MDU}, 32'd0);
        check("arst_wen", {31'b0, bus.Wt_Enable_o_MDU}, 32'd0);
        check("arst_data", bus.Wt_Data_o_MDU, 32'd0);
        check("arst_addr", {27'b0, bus.Wt_Addr_o_MDU}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            check("post_rst_busy", {31'b0, bus.busy_o_MDU}, 32'd0);
            check("post_rst_wen", {31'b0, bus.Wt_Enable_o_MDU}, 32'd0);
        end

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/mdu_seq.md
# mdu_seq

Multi-cycle sequencer for the RV32M multiply/divide unit beside the EXE stage. It accepts one M-extension operation from ID_EXE and runs a 32-iteration shift-add multiply or restoring divide. While it works it stalls the pipeline, then presents a one-cycle register write toward EXE_MEM in the same Wt_* format the ALU path uses.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold the value XLEN.

- clk_i_MDU  input  1  clock, rising edge.
- rst_i_MDU  input  1  asynchronous, active-high reset.
- start_i_MDU  input  1  the instruction in EXE is an M-op; level, held while stall_o_MDU is high.
- op_i_MDU  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- Rd_Data1_i_MDU  input  32  rs1 value.
- Rd_Data2_i_MDU  input  32  rs2 value.
- Wt_Addr_i_MDU  input  5  rd.
- regWrite_i_MDU  input  1  write enable from decode.
- flush_i_MDU  input  1  abort the current operation, no write.
- stall_o_MDU  output  1  hold IF/ID/EXE stages.
- busy_o_MDU  output  1  state is not IDLE.
- Wt_Data_o_MDU  output  32  result.
- Wt_Addr_o_MDU  output  5  rd of the result.
- Wt_Enable_o_MDU  output  1  one-cycle write strobe.

## Operation
- States: IDLE, CALC, DONE.
- IDLE → CALC when start_i_MDU=1 and flush_i_MDU=0. At that edge the block latches op, rd and regWrite, loads |rs1| and |rs2| as the operands of the unsigned core, records the result sign, and clears the counter.
  - Signed operands: MULH, DIV and REM treat both as signed. MULHSU treats only rs1 as signed. MUL and the unsigned ops take raw values.
- Special divides go IDLE → DONE directly with no CALC cycles.
  - rs2=0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → rs1.
  - DIV or REM with rs1=0x80000000 and rs2=0xFFFFFFFF: DIV → 0x80000000, REM → 0.
- CALC performs one iteration per cycle and increments the counter. After the iteration with counter=XLEN-1 it goes to DONE.
  - Multiply: 64-bit accumulator, add-and-shift on multiplier LSB.
  - Divide: restoring; 33-bit partial remainder; quotient bit shifted in each cycle.
- Sign fix on the CALC→DONE edge:
  - Product is negated (two's complement, 64-bit) if the signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Result select: MUL → low 32 bits; MULH/MULHSU/MULHU → high 32 bits.
- DONE: Wt_Data/Wt_Addr are valid and Wt_Enable_o_MDU = latched regWrite. Next state is always IDLE.
- rd=0: Wt_Enable is still driven by regWrite; x0 suppression is done by the register file.
- stall_o_MDU = (IDLE & start_i_MDU & ~flush_i_MDU) | CALC. It is combinational and low in DONE, so the instruction leaves EXE in the DONE cycle.
- start_i_MDU is ignored outside IDLE. In DONE, the start level still present for the finishing instruction must not retrigger the block. Guard: a new start is accepted only in IDLE, and the pipeline advances in DONE.
- flush_i_MDU has priority in every state. Next state is IDLE, Wt_Enable is 0, and the datapath registers may keep stale values.
- Reset forces IDLE at once (asynchronous). Reset values: stall 0, busy 0, Wt_Data 0, Wt_Addr 0, Wt_Enable 0, counter 0.

## Timing
- Start accepted at edge E0. CALC spans E0..E32 (32 cycles). DONE is the cycle after edge E32, with the write strobe high for exactly 1 cycle.
- Total stall for normal ops: 33 cycles (start cycle plus 32 CALC cycles). The result appears 33 cycles after start is first seen.
- Special divides: stall for 1 cycle; DONE is the next cycle.
- Wt_Data/Wt_Addr/Wt_Enable are registered outputs. busy_o_MDU is registered (state≠IDLE).
- Back-to-back M-ops: the second start is seen in the IDLE cycle after DONE. There is no bubble beyond the pipeline refill.
- Reset asserted mid-CALC: outputs are zero asynchronously. After release, the block is in IDLE and needs a fresh start.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD → stall high 33 cycles, then Wt_Data=0xFFFFFFEB, Wt_Enable=1 for one cycle, Wt_Addr=rd.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) by 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; all with a 1-cycle stall.
- flush_i_MDU pulsed at CALC cycle 10 → IDLE next cycle, stall low, no Wt_Enable. A following DIVU 9/3 → 3 with full latency.
- rst_i_MDU asserted mid-CALC → all outputs 0 immediately. After release, with start low, there is no write and busy stays 0.
